// File: rtl/text_line_sequencer.sv
// ---------------------------------------------------------------------------
// text_line_sequencer
//
// Sequences a line of up to MAX_CHARS characters onto the single-character
// text_display datapath.  A frame-timed typewriter reveal exposes one more
// character every REVEAL_FRAMES frames.  The completed line is then held
// until the next start or an abort.
//
// Optional build macro: TEXT_BLINK_EN
//   When defined, the held line blinks with a half-period of BLINK_FRAMES
//   frames.  When undefined, the held line is shown steadily.
//
// Ports:
//   clk_0        pixel clock
//   rst          asynchronous active-low reset
//   pixel_x/y    current pixel position
//   frame_start  one-cycle pulse, once per frame
//   wr_en/wr_addr/wr_char   line buffer write port
//   line_x/line_y/line_len  line origin and length, latched on start
//   start        begin (or restart) the reveal
//   abort        return to IDLE; wins over start
//   char_code    character for the current pixel (7'h20 when blank)
//   x_pos/y_pos  origin of the current character slot
//   active       registered, high in REVEAL or HOLD
//   done         registered one-cycle pulse when the reveal completes
// ---------------------------------------------------------------------------
module text_line_sequencer #(
    parameter int MAX_CHARS     = 16,
    parameter int SCALE         = 4,
    parameter int REVEAL_FRAMES = 8,
    parameter int BLINK_FRAMES  = 30
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       frame_start,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [6:0] wr_char,
    input  logic [9:0] line_x,
    input  logic [9:0] line_y,
    input  logic [4:0] line_len,
    input  logic       start,
    input  logic       abort,
    output logic [6:0] char_code,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic       active,
    output logic       done
);

    localparam int CHAR_W = 6 * SCALE;
    localparam int FCW    = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
    localparam logic [6:0] SPACE = 7'h20;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REVEAL = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [4:0]       shown_q, shown_d;
    logic [4:0]       len_q, len_d;
    logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             active_q, active_d;
    logic             done_q, done_d;
    logic             hold_entry_q, hold_entry_d;
    logic [6:0]       buf_q [MAX_CHARS];

    logic             restart_s;
    logic [4:0]       len_clamp_s;
    logic [9:0]       rel_s;
    logic [9:0]       slot_s;
    logic             in_line_s;
    logic             blank_s;
    logic [6:0]       char_code_s;
    logic [9:0]       x_pos_s;

    // pixel_y is part of the text_display pixel bus but the line is a single
    // row of slots, so only the column selects a character.
    logic             unused_pixel_y_s;
    assign unused_pixel_y_s = ^pixel_y;

    assign len_clamp_s = (line_len > 5'(MAX_CHARS)) ? 5'(MAX_CHARS) : line_len;

    // State register plus latched line parameters and registered flags.
    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            shown_q      <= 5'd0;
            len_q        <= 5'd0;
            frame_cnt_q  <= '0;
            x_q          <= 10'd0;
            y_q          <= 10'd0;
            active_q     <= 1'b0;
            done_q       <= 1'b0;
            hold_entry_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shown_q      <= shown_d;
            len_q        <= len_d;
            frame_cnt_q  <= frame_cnt_d;
            x_q          <= x_d;
            y_q          <= y_d;
            active_q     <= active_d;
            done_q       <= done_d;
            hold_entry_q <= hold_entry_d;
        end
    end

    // Line buffer; writes are accepted in every state.
    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < MAX_CHARS; i++) begin
                buf_q[i] <= SPACE;
            end
        end else if (wr_en && (int'(wr_addr) < MAX_CHARS)) begin
            buf_q[wr_addr] <= wr_char;
        end
    end

    // Next-state logic: abort beats start, start beats a coincident frame_start.
    always_comb begin
        state_d     = state_q;
        shown_d     = shown_q;
        len_d       = len_q;
        frame_cnt_d = frame_cnt_q;
        x_d         = x_q;
        y_d         = y_q;
        restart_s   = 1'b0;
        if (abort) begin
            state_d     = ST_IDLE;
            shown_d     = 5'd0;
            frame_cnt_d = '0;
        end else if (start) begin
            restart_s   = 1'b1;
            x_d         = line_x;
            y_d         = line_y;
            len_d       = len_clamp_s;
            shown_d     = 5'd0;
            frame_cnt_d = '0;
            // An empty line has nothing to reveal and completes at once.
            state_d     = (len_clamp_s == 5'd0) ? ST_HOLD : ST_REVEAL;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_REVEAL: begin
                    if (frame_start) begin
                        if (frame_cnt_q == FCW'(REVEAL_FRAMES - 1)) begin
                            frame_cnt_d = '0;
                            shown_d     = shown_q + 5'd1;
                            if ((shown_q + 5'd1) == len_q) begin
                                state_d = ST_HOLD;
                            end else begin
                                state_d = ST_REVEAL;
                            end
                        end else begin
                            frame_cnt_d = frame_cnt_q + FCW'(1);
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q;
                    end
                end
                ST_HOLD: begin
                    shown_d = len_q;
                end
                default: begin
                    state_d = ST_IDLE;
                    shown_d = 5'd0;
                end
            endcase
        end
    end

`ifdef TEXT_BLINK_EN
    localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
    logic           blank_q, blank_d;

    // Blink phase register; only ever non-zero while holding a line.
    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            blink_cnt_q <= '0;
            blank_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blank_q     <= blank_d;
        end
    end

    // Blink counter: runs only while staying in HOLD, clears on any other path.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blank_d     = blank_q;
        if ((state_q == ST_HOLD) && (state_d == ST_HOLD) && !restart_s) begin
            if (frame_start) begin
                if (blink_cnt_q == BCW'(BLINK_FRAMES - 1)) begin
                    blink_cnt_d = '0;
                    blank_d     = ~blank_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + BCW'(1);
                end
            end else begin
                blink_cnt_d = blink_cnt_q;
            end
        end else begin
            blink_cnt_d = '0;
            blank_d     = 1'b0;
        end
    end

    assign blank_s = blank_q;
`else
    assign blank_s = 1'b0;
`endif

    // Registered status flags and zero-latency pixel decode.
    always_comb begin
        active_d     = (state_d != ST_IDLE);
        // A restart that lands straight back in HOLD (empty line) is a new completion.
        hold_entry_d = (state_d == ST_HOLD) && ((state_q != ST_HOLD) || restart_s);
        // done follows HOLD entry by one cycle unless HOLD is left in between.
        done_d       = hold_entry_q && (state_q == ST_HOLD) && (state_d == ST_HOLD) && !restart_s;

        rel_s     = pixel_x - x_q;
        slot_s    = rel_s / 10'(CHAR_W);
        in_line_s = (state_q != ST_IDLE) && (pixel_x >= x_q) && (slot_s < {5'd0, len_q});
        if (in_line_s) begin
            x_pos_s = x_q + (slot_s * 10'(CHAR_W));
            if ((slot_s < {5'd0, shown_q}) && !blank_s) begin
                char_code_s = buf_q[slot_s[3:0]];
            end else begin
                char_code_s = SPACE;
            end
        end else begin
            x_pos_s     = x_q;
            char_code_s = SPACE;
        end
    end

    assign char_code = char_code_s;
    assign x_pos     = x_pos_s;
    assign y_pos     = y_q;
    assign active    = active_q;
    assign done      = done_q;

endmodule

// File: tb/tb_text_line_sequencer.sv
module tb_text_line_sequencer;

    logic       clk_0 = 1'b0;
    logic       rst;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       frame_start;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [6:0] wr_char;
    logic [9:0] line_x;
    logic [9:0] line_y;
    logic [4:0] line_len;
    logic       start;
    logic       abort;
    logic [6:0] char_code;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic       active;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    text_line_sequencer #(
        .MAX_CHARS(16), .SCALE(4), .REVEAL_FRAMES(8), .BLINK_FRAMES(30)
    ) dut (
        .clk_0(clk_0), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .frame_start(frame_start), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_char(wr_char), .line_x(line_x), .line_y(line_y),
        .line_len(line_len), .start(start), .abort(abort),
        .char_code(char_code), .x_pos(x_pos), .y_pos(y_pos),
        .active(active), .done(done)
    );

    always #5 clk_0 = ~clk_0;

    // Count done pulses away from the active edge.
    always @(negedge clk_0) begin
        if (done === 1'b1) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_0);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
        end
    endtask

    task automatic set_pix(input logic [9:0] px);
        pixel_x = px;
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [6:0] c);
        wr_en = 1'b1; wr_addr = a; wr_char = c;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_start(input logic [9:0] x, input logic [9:0] y,
                            input logic [4:0] len, input logic fs);
        line_x = x; line_y = y; line_len = len;
        start = 1'b1; frame_start = fs;
        tick();
        start = 1'b0; frame_start = 1'b0;
    endtask

    initial begin
        rst = 1'b0; pixel_x = 10'd0; pixel_y = 10'd60; frame_start = 1'b0;
        wr_en = 1'b0; wr_addr = 4'd0; wr_char = 7'd0;
        line_x = 10'd0; line_y = 10'd0; line_len = 5'd0;
        start = 1'b0; abort = 1'b0;

        // Reset state
        tick(); tick();
        check_eq("rst_active", 32'(active), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_xpos", 32'(x_pos), 32'd0);
        check_eq("rst_ypos", 32'(y_pos), 32'd0);
        rst = 1'b1;
        tick(); tick();
        set_pix(10'd0);   check_eq("idle_char_0", 32'(char_code), 32'h20);
        set_pix(10'd100); check_eq("idle_char_100", 32'(char_code), 32'h20);
        set_pix(10'd500); check_eq("idle_char_500", 32'(char_code), 32'h20);
        check_eq("idle_active", 32'(active), 32'd0);

        // "WIN" at (100,50)
        wr(4'd0, 7'h57); wr(4'd1, 7'h49); wr(4'd2, 7'h4E);
        do_start(10'd100, 10'd50, 5'd3, 1'b0);
        check_eq("start_active", 32'(active), 32'd1);
        set_pix(10'd100); check_eq("rev0_char", 32'(char_code), 32'h20);
        check_eq("rev0_ypos", 32'(y_pos), 32'd50);
        frames(7);
        check_eq("rev7_char", 32'(char_code), 32'h20);
        frames(1);
        set_pix(10'd100); check_eq("rev8_char_w", 32'(char_code), 32'h57);
        check_eq("rev8_xpos", 32'(x_pos), 32'd100);
        set_pix(10'd124); check_eq("rev8_char1", 32'(char_code), 32'h20);
        check_eq("rev8_xpos1", 32'(x_pos), 32'd124);
        set_pix(10'd99);  check_eq("left_char", 32'(char_code), 32'h20);
        check_eq("left_xpos", 32'(x_pos), 32'd100);
        frames(16);
        check_eq("done_not_yet", 32'(done), 32'd0);
        tick();
        check_eq("done_pulse", 32'(done), 32'd1);
        tick();
        check_eq("done_drop", 32'(done), 32'd0);
        check_eq("done_cnt1", 32'(done_cnt), 32'd1);
        set_pix(10'd148); check_eq("hold_char_n", 32'(char_code), 32'h4E);
        check_eq("hold_xpos_n", 32'(x_pos), 32'd148);
        set_pix(10'd170); check_eq("hold_mid_slot2", 32'(char_code), 32'h4E);
        check_eq("hold_xpos_mid", 32'(x_pos), 32'd148);
        set_pix(10'd172); check_eq("past_len_char", 32'(char_code), 32'h20);
        check_eq("past_len_xpos", 32'(x_pos), 32'd100);
        wr(4'd1, 7'h41);
        set_pix(10'd124); check_eq("live_write", 32'(char_code), 32'h41);
        check_eq("hold_active", 32'(active), 32'd1);

        // Restart, then abort after 10 frames
        do_start(10'd100, 10'd50, 5'd3, 1'b0);
        frames(10);
        set_pix(10'd100); check_eq("pre_abort_w", 32'(char_code), 32'h57);
        set_pix(10'd124); check_eq("pre_abort_1", 32'(char_code), 32'h20);
        abort = 1'b1; tick(); abort = 1'b0;
        check_eq("abort_active", 32'(active), 32'd0);
        set_pix(10'd100); check_eq("abort_char", 32'(char_code), 32'h20);
        tick(); tick(); tick();
        check_eq("abort_no_done", 32'(done_cnt), 32'd1);

        // Length clamp: 20 -> 16
        for (int i = 3; i < 16; i++) wr(4'(i), 7'(8'h40 + i));
        do_start(10'd0, 10'd10, 5'd20, 1'b0);
        frames(127);
        check_eq("clamp_no_done", 32'(done_cnt), 32'd1);
        set_pix(10'd336); check_eq("clamp_slot14", 32'(char_code), 32'h4E);
        set_pix(10'd360); check_eq("clamp_slot15_hidden", 32'(char_code), 32'h20);
        frames(1);
        set_pix(10'd360); check_eq("clamp_slot15", 32'(char_code), 32'h4F);
        check_eq("clamp_xpos15", 32'(x_pos), 32'd360);
        set_pix(10'd384); check_eq("clamp_slot16", 32'(char_code), 32'h20);
        check_eq("clamp_xpos16", 32'(x_pos), 32'd0);
        check_eq("clamp_ypos", 32'(y_pos), 32'd10);
        tick(); tick();
        check_eq("clamp_done", 32'(done_cnt), 32'd2);

        // start + abort together: abort wins
        line_x = 10'd100; line_y = 10'd50; line_len = 5'd3;
        start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
        check_eq("start_abort_idle", 32'(active), 32'd0);

        // start coincident with frame_start: that frame is not counted
        do_start(10'd100, 10'd50, 5'd3, 1'b1);
        frames(7);
        set_pix(10'd100); check_eq("coinc_7", 32'(char_code), 32'h20);
        frames(1);
        set_pix(10'd100); check_eq("coinc_8", 32'(char_code), 32'h57);

        // Empty line: HOLD at once, done one cycle later
        abort = 1'b1; tick(); abort = 1'b0;
        do_start(10'd100, 10'd50, 5'd0, 1'b0);
        check_eq("len0_active", 32'(active), 32'd1);
        check_eq("len0_done_0", 32'(done), 32'd0);
        tick();
        check_eq("len0_done_1", 32'(done), 32'd1);
        tick();
        check_eq("len0_done_2", 32'(done), 32'd0);
        set_pix(10'd100); check_eq("len0_char", 32'(char_code), 32'h20);
        check_eq("len0_xpos", 32'(x_pos), 32'd100);
        tick();
        check_eq("len0_done_cnt", 32'(done_cnt), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/text_line_sequencer.md
Name: text_line_sequencer

Overview:
- Sequences a line of up to MAX_CHARS characters onto the single-character text_display datapath. For each pixel it supplies char_code, x_pos and y_pos.
- Provides a frame-timed "typewriter" reveal, one extra character every REVEAL_FRAMES frames, then holds the completed line until it is aborted.
- Sits between game-state logic (messages such as "PLAYER 1 WINS") and text_display, in the clk_0 pixel domain.

Parameters:
MAX_CHARS, 16, line buffer depth; the RTL is written for 16 (4-bit address, 5-bit length).
SCALE, 4, glyph scale; must match the text_display instance; character pitch CHAR_W = 6*SCALE pixels.
REVEAL_FRAMES, 8, frame_start pulses per newly revealed character (must be >= 1).
BLINK_FRAMES, 30, frame_start pulses per blink half-period (used only with TEXT_BLINK_EN).

Ports:
clk_0  in  1  pixel clock
rst  in  1  asynchronous, active-low reset
pixel_x  in  10  current pixel column
pixel_y  in  10  current pixel row
frame_start  in  1  1-cycle pulse, once per frame
wr_en  in  1  buffer write strobe
wr_addr  in  4  buffer slot to write
wr_char  in  7  ASCII code to write
line_x  in  10  line origin x, sampled on start
line_y  in  10  line origin y, sampled on start
line_len  in  5  number of characters, sampled on start
start  in  1  1-cycle pulse: begin reveal
abort  in  1  1-cycle pulse: return to IDLE
char_code  out  7  character for current pixel, to text_display
x_pos  out  10  origin x of current slot, to text_display
y_pos  out  10  line origin y, to text_display
active  out  1  high in REVEAL or HOLD
done  out  1  1-cycle pulse when reveal completes

Behaviour:
- Reset (rst low, asynchronous):
  - State = IDLE; shown = 0; frame_cnt = 0; all buffer slots = 7'h20.
  - Latched x, y and len = 0; active = 0; done = 0.
- Buffer:
  - On wr_en, buf[wr_addr] <= wr_char. Writes are accepted in any state.
  - wr_addr >= MAX_CHARS is ignored.
  - A write to a slot that is already revealed shows on the next cycle.
- States:
  - IDLE -> REVEAL on start. This latches line_x, line_y and min(line_len, MAX_CHARS), and clears shown and frame_cnt.
  - If the latched len is 0, go IDLE -> HOLD directly with shown = 0, and pulse done on the following cycle.
  - REVEAL: frame_cnt increments on each frame_start.
    - When frame_cnt reaches REVEAL_FRAMES-1 on a frame_start, frame_cnt wraps to 0 and shown increments.
    - When shown becomes len, go to HOLD and assert done for exactly 1 cycle (the cycle after the transition is registered).
  - HOLD: shown = len and stays constant; remain in HOLD until abort or start.
  - start in REVEAL or HOLD restarts: re-latch the inputs, shown = 0, frame_cnt = 0, state REVEAL.
  - abort in any state -> IDLE, shown = 0, no done pulse.
  - start and abort in the same cycle: abort wins.
  - start coincident with frame_start: start wins; that frame_start is not counted.
- Pixel decode (combinational from pixel_x/pixel_y and registered state, zero latency, so it stays aligned with text_display's own pixel sampling):
  - rel = pixel_x - latched x, 10-bit unsigned.
  - slot = rel / CHAR_W; constant division is acceptable.
  - The pixel is in the line when pixel_x >= latched x and slot < len.
  - In the line: x_pos = latched x + slot*CHAR_W, truncated to 10 bits; y_pos = latched y.
  - char_code = buf[slot] if slot < shown, else 7'h20.
  - Outside the line, or in IDLE: char_code = 7'h20, x_pos = latched x, y_pos = latched y.
- Reset outputs: char_code = 7'h20, x_pos = 0, y_pos = 0, active = 0, done = 0.
- active = (state != IDLE), registered.

Optional Feature:
- Macro: TEXT_BLINK_EN.
- Defined:
  - In HOLD, a blink counter counts frame_start pulses; every BLINK_FRAMES pulses it toggles a blank flag.
  - While blank = 1, all in-line char_code values are 7'h20.
  - The blink counter and blank flag clear on entry to HOLD, on abort and on reset.
  - Blink never applies in REVEAL.
- Undefined: no blink logic is present; HOLD displays steadily.

Test Plan:
- Reset release, no activity -> char_code = 7'h20 for every pixel; active = 0, done = 0.
- Write "WIN" to slots 0-2; start with line_x = 100, line_y = 50, line_len = 3; REVEAL_FRAMES = 8.
  - 8 frame_starts -> pixel_x = 100 gives char_code 'W', x_pos = 100; pixel_x = 124 gives 7'h20.
  - After 24 frame_starts -> pixel_x = 148 gives 'N', x_pos = 148; done pulses once; state is HOLD.
- Abort after 10 frame_starts -> active drops next cycle, no done pulse, char_code = 7'h20 everywhere.
- start with line_len = 20 -> len clamps to 16; done after 128 frame_starts; pixel_x = line_x + 16*24 -> 7'h20.
- Simultaneous start + abort -> IDLE. start coincident with frame_start -> first reveal occurs 8 frame_starts later. line_len = 0 -> done 1 cycle after HOLD entry.
- TEXT_BLINK_EN, BLINK_FRAMES = 30, in HOLD -> in-line chars blank for 30 frames, visible for 30, repeating.
